// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared types and constants for the 4-way round-robin arbiter.
//           NREQ  - number of requesters
//           IDX_W - width of an encoded requester index
//           arb_state_e - arbiter FSM state encoding (IDLE, GRANT)
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/onehot_enc4.sv
`default_nettype none
// ============================================================================
// Module  : onehot_enc4
// Purpose : Combinational 4-bit one-hot to 2-bit binary index encoder.
//           An all-zero input encodes to index 0.
// Ports   : onehot [3:0] in  - one-hot (or zero) vector
//           idx    [1:0] out - binary index of the set bit
// Revision: 1.0 - initial release
// ============================================================================
module onehot_enc4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    // OR-form encoder: cheap and well-defined for the all-zero input.
    assign idx[0] = onehot[1] | onehot[3];
    assign idx[1] = onehot[2] | onehot[3];

endmodule : onehot_enc4
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter4
// Purpose : Round-robin arbiter sharing one resource among four requesters.
//           A grant is held until the owner asserts done, drops its request,
//           or the hold limit HOLD_MAX expires (0 = no limit).
// Ports   : clk       in   rising-edge clock
//           rst_n     in   asynchronous active-low reset
//           enable    in   allow new grants (does not cut an active grant)
//           req [3:0] in   level-sensitive requests
//           done      in   owner finished (sampled only while granted)
//           gnt [3:0] out  registered one-hot grant
//           gnt_idx   out  binary index of gnt
//           gnt_valid out  high while a grant is active
//           timeout   out  one-cycle pulse on a hold-limit release
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int c_cnt_w = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = '1;
    localparam logic [c_cnt_w-1:0] c_hold_last =
        (HOLD_MAX == 0) ? '0 : c_cnt_w'(HOLD_MAX - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;

    logic [NREQ-1:0]     w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_found;
    logic                w_rel_drop;
    logic                w_rel_limit;
    logic                w_release;

    // Round-robin search starting just after the last winner and ending on it.
    always_comb begin
        logic [IDX_W-1:0] cand;
        w_found   = 1'b0;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_q + IDX_W'(i);
            if (!w_found && req[cand]) begin
                w_found   = 1'b1;
                w_win_idx = cand;
            end
        end
        w_win_oh[w_win_idx] = w_found;
    end

    assign w_rel_drop  = ~req[gnt_idx_q];
    assign w_rel_limit = (HOLD_MAX != 0) && (cnt_q == c_hold_last);
    assign w_release   = done | w_rel_drop | w_rel_limit;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (enable && w_found) begin
                    gnt_d       = w_win_oh;
                    gnt_valid_d = 1'b1;
                    last_d      = w_win_idx;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (w_release) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                    // Only flag a timeout when the limit is the sole cause.
                    timeout_d   = w_rel_limit & ~done & ~w_rel_drop;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // Index is encoded from the next grant so both register on the same edge.
    onehot_enc4 u_enc (
        .onehot (gnt_d),
        .idx    (gnt_idx_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : rr_arbiter4
`default_nettype wire
